// File: rtl/kamikaze_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and
// the load/store unit; one outstanding access, LS priority with a streak cap.
module kamikaze_mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction fetch
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // load/store unit
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_be_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                we_q, we_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         ls_rdata_q, ls_rdata_d;
  logic                if_gnt, ls_gnt;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Grants are suppressed while reset is held so gnt outputs stay 0.
        if (!rst_i) begin
          if (ls_req_i && (!if_req_i || streak_q != STREAK_MAX)) begin
            ls_gnt = 1'b1;
          end else if (if_req_i) begin
            if_gnt = 1'b1;
          end
        end

        if (ls_gnt) begin
          owner_d  = OWN_LS;
          addr_d   = ls_addr_i;
          wdata_d  = ls_wdata_i;
          be_d     = ls_be_i;
          we_d     = ls_we_i;
          state_d  = S_REQ;
          if (if_req_i) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (if_gnt) begin
          owner_d  = OWN_IF;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          be_d     = 4'hF;
          we_d     = 1'b0;
          streak_d = '0;
          state_d  = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_gnt_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata_i;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule
